// File: rtl/my_aes_inv_key_mem_pkg.sv
// Shared AES key-schedule definitions.
// Holds the key-memory FSM state encoding, the AES-128 round count and the
// round-constant values used when walking the schedule backwards.
package my_aes_inv_key_mem_pkg;

  localparam logic [3:0] AES_128_NUM_ROUNDS = 4'ha;

  // Round constant that produced the round-10 key. Stepping back from
  // round 10 starts here.
  localparam logic [7:0] AES_INV_RCON_INIT = 8'h36;

  typedef enum logic {
    CTRL_IDLE   = 1'b0,
    CTRL_OUTPUT = 1'b1
  } key_mem_state_e;

  // Inverse of the GF(2^8) xtime step: divides rcon by x.
  // A set LSB means the forward step reduced by 0x1b, so undo that first
  // and put back the bit that overflowed out of the top.
  function automatic logic [7:0] inv_xtime(input logic [7:0] rcon);
    if (rcon[0]) begin
      inv_xtime = ((rcon ^ 8'h1b) >> 1) | 8'h80;
    end else begin
      inv_xtime = rcon >> 1;
    end
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box applied to each byte of a 32-bit word.
// Ports:
//   sboxw     in  32  word to substitute
//   new_sboxw out 32  byte-wise SubBytes result
module aes_sbox (
  input  logic [31:0] sboxw,
  output logic [31:0] new_sboxw
);

  // Entry i sits at bits [2047-8*i -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    sub_byte = SBOX_TBL[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  always_comb begin
    new_sboxw = {sub_byte(sboxw[31:24]), sub_byte(sboxw[23:16]),
                 sub_byte(sboxw[15:8]),  sub_byte(sboxw[7:0])};
  end

endmodule

// File: rtl/my_aes_inv_key_mem.sv
// AES-128 inverse key memory.
// Given the last (round-10) round key, walks the key schedule backwards and
// hands out round keys 10 down to 0, one per consumer acknowledge.
// Ports:
//   clk            in   1    rising-edge clock
//   reset          in   1    asynchronous active-high reset
//   key            in   128  round-10 key, sampled on accepted init
//   init           in   1    start expansion (honoured only when ready)
//   roundkey_ack   in   1    consumer has taken the current roundkey
//   round          out  4    index of presented round key
//   roundkey       out  128  current round key, w0 in [127:96]
//   roundkey_valid out  1    roundkey/round are valid
//   ready          out  1    idle, able to accept init
//
// state       | meaning
// CTRL_IDLE   | waiting for init; ready=1
// CTRL_OUTPUT | presenting key[round]; advances on roundkey_ack
module my_aes_inv_key_mem #(
  parameter logic [3:0] AES_128_NUM_ROUNDS = my_aes_inv_key_mem_pkg::AES_128_NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key,
  input  logic         init,
  input  logic         roundkey_ack,
  output logic [3:0]   round,
  output logic [127:0] roundkey,
  output logic         roundkey_valid,
  output logic         ready
);

  import my_aes_inv_key_mem_pkg::*;

  key_mem_state_e state;
  logic [127:0]   key_reg;
  logic [3:0]     round_reg;
  logic [7:0]     rcon_reg;
  logic           ready_reg;
  logic           valid_reg;

  logic [31:0]    w0, w1, w2, w3;
  logic [31:0]    p0, p1, p2, p3;
  logic [31:0]    rot_p3;
  logic [31:0]    sub_rot_p3;
  logic [127:0]   prev_key;

  // Inverting w[i] = w[i-4] ^ w[i-1]: the upper three words fall out of
  // neighbouring XORs, and p3 recovered first feeds the g() term for p0.
  always_comb begin
    w0       = key_reg[127:96];
    w1       = key_reg[95:64];
    w2       = key_reg[63:32];
    w3       = key_reg[31:0];
    p3       = w3 ^ w2;
    p2       = w2 ^ w1;
    p1       = w1 ^ w0;
    rot_p3   = {p3[23:0], p3[31:24]};
    p0       = w0 ^ sub_rot_p3 ^ {rcon_reg, 24'h0};
    prev_key = {p0, p1, p2, p3};
  end

  aes_sbox u_sbox (
    .sboxw     (rot_p3),
    .new_sboxw (sub_rot_p3)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CTRL_IDLE;
      key_reg   <= 128'h0;
      round_reg <= 4'h0;
      rcon_reg  <= 8'h00;
      ready_reg <= 1'b1;
      valid_reg <= 1'b0;
    end else begin
      case (state)
        CTRL_IDLE: begin
          if (init) begin
            key_reg   <= key;
            round_reg <= AES_128_NUM_ROUNDS;
            rcon_reg  <= AES_INV_RCON_INIT;
            state     <= CTRL_OUTPUT;
            ready_reg <= 1'b0;
            valid_reg <= 1'b1;
          end
        end
        CTRL_OUTPUT: begin
          if (roundkey_ack) begin
            if (round_reg != 4'h0) begin
              key_reg   <= prev_key;
              round_reg <= round_reg - 4'h1;
              rcon_reg  <= inv_xtime(rcon_reg);
            end else begin
              // Round-0 (cipher) key stays in key_reg after handoff.
              round_reg <= 4'h0;
              state     <= CTRL_IDLE;
              ready_reg <= 1'b1;
              valid_reg <= 1'b0;
            end
          end
        end
        default: begin
          state     <= CTRL_IDLE;
          ready_reg <= 1'b1;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign roundkey       = key_reg;
  assign round          = round_reg;
  assign roundkey_valid = valid_reg;
  assign ready          = ready_reg;

endmodule

// File: tb/tb_my_aes_inv_key_mem.sv
module tb_my_aes_inv_key_mem;

  logic         clk;
  logic         reset;
  logic [127:0] key;
  logic         init;
  logic         roundkey_ack;
  logic [3:0]   round;
  logic [127:0] roundkey;
  logic         roundkey_valid;
  logic         ready;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_keys [11];

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] rkey;
  } vec_t;

  vec_t vecs [11];

  localparam logic [2047:0] TB_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  my_aes_inv_key_mem dut (
    .clk            (clk),
    .reset          (reset),
    .key            (key),
    .init           (init),
    .roundkey_ack   (roundkey_ack),
    .round          (round),
    .roundkey       (roundkey),
    .roundkey_valid (roundkey_valid),
    .ready          (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_sub(input logic [7:0] b);
    int idx;
    idx = 2047 - 8 * int'(b);
    tb_sub = TB_SBOX[idx -: 8];
  endfunction

  function automatic logic [31:0] tb_sub_word(input logic [31:0] w);
    tb_sub_word = {tb_sub(w[31:24]), tb_sub(w[23:16]), tb_sub(w[15:8]), tb_sub(w[7:0])};
  endfunction

  function automatic logic [7:0] fwd_rcon(input int n);
    case (n)
      1: fwd_rcon = 8'h01;  2: fwd_rcon = 8'h02;  3: fwd_rcon = 8'h04;
      4: fwd_rcon = 8'h08;  5: fwd_rcon = 8'h10;  6: fwd_rcon = 8'h20;
      7: fwd_rcon = 8'h40;  8: fwd_rcon = 8'h80;  9: fwd_rcon = 8'h1b;
      10: fwd_rcon = 8'h36;
      default: fwd_rcon = 8'h00;
    endcase
  endfunction

  // Forward AES-128 key expansion; fills exp_keys[0..10] indexed by round.
  task automatic fill_exp(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    w[0] = k[127:96];
    w[1] = k[95:64];
    w[2] = k[63:32];
    w[3] = k[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = tb_sub_word({t[23:0], t[31:24]}) ^ {fwd_rcon(i / 4), 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // mode 0: ack held high; 1: random ack; 2: 20 stall cycles then random ack.
  // inj_round: pulse init with another key while at that round (-1 = never).
  // rst_round: assert reset while at that round and abort (-1 = never).
  // Entered and left at a negedge.
  task automatic run_seq(input logic [127:0] k, input int mode, input int inj_round,
                         input int rst_round);
    int  exp_r;
    int  cycles;
    int  stall;
    logic ack_now;
    key = k;
    init = 1'b1;
    roundkey_ack = (mode == 0);
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    exp_r = 10;
    cycles = 0;
    stall = 0;
    while (exp_r >= 0 && cycles < 200) begin
      chk("valid", 128'(roundkey_valid), 128'(1));
      chk("round", 128'(round), 128'(exp_r));
      chk("roundkey", roundkey, exp_keys[exp_r]);
      if (exp_r == rst_round) begin
        reset = 1'b1;
        #1;
        chk("abort_ready", 128'(ready), 128'(1));
        chk("abort_valid", 128'(roundkey_valid), 128'(0));
        chk("abort_round", 128'(round), 128'(0));
        chk("abort_key", roundkey, 128'h0);
        @(negedge clk);
        reset = 1'b0;
        roundkey_ack = 1'b0;
        init = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_ready", 128'(ready), 128'(1));
        chk("idle_valid", 128'(roundkey_valid), 128'(0));
        return;
      end
      if (exp_r == inj_round) begin
        init = 1'b1;
        key = ~k;
      end else begin
        init = 1'b0;
      end
      if (mode == 0) ack_now = 1'b1;
      else if (mode == 2 && stall < 20) ack_now = 1'b0;
      else ack_now = 1'($urandom_range(0, 1));
      stall++;
      roundkey_ack = ack_now;
      @(posedge clk);
      if (ack_now) exp_r--;
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 200) chk("seq_timeout", 128'(cycles), 128'(0));
    init = 1'b0;
    roundkey_ack = 1'b0;
    chk("end_ready", 128'(ready), 128'(1));
    chk("end_valid", 128'(roundkey_valid), 128'(0));
    chk("end_round", 128'(round), 128'(0));
    chk("end_key", roundkey, exp_keys[0]);
  endtask

  initial begin
    vecs[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    vecs[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    vecs[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    vecs[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    vecs[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    vecs[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    vecs[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    vecs[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    reset = 1'b1;
    key = 128'h0;
    init = 1'b0;
    roundkey_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 128'(ready), 128'(1));
    chk("rst_valid", 128'(roundkey_valid), 128'(0));
    chk("rst_round", 128'(round), 128'(0));
    chk("rst_key", roundkey, 128'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_init", 128'(ready), 128'(1));

    // Table vectors, ack held high with init: 11 keys then ready on cycle 12.
    for (int i = 0; i < 11; i++) exp_keys[vecs[i].rnd] = vecs[i].rkey;
    run_seq(vecs[10].rkey, 0, -1, -1);

    // Back-pressure then random ack.
    run_seq(vecs[10].rkey, 2, -1, -1);

    // Spurious init at round 6 must not disturb the sequence.
    run_seq(vecs[10].rkey, 0, 6, -1);

    // Reset at round 5, then a fresh full run.
    run_seq(vecs[10].rkey, 1, -1, 5);
    run_seq(vecs[10].rkey, 0, -1, -1);

    // Round trip on random cipher keys via the forward expansion model.
    for (int n = 0; n < 100; n++) begin
      fill_exp({$urandom, $urandom, $urandom, $urandom});
      run_seq(exp_keys[10], (n % 2 == 0) ? 0 : 1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
